// File: rtl/alu_pkg.sv
// Shared definitions for the beat-sequenced ALU: opcode encodings, controller
// state enum and beat-count helpers.
package alu_pkg;

    // mode = 0 (arithmetic) opcodes
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_INC = 3'b110;

    // mode = 1 (logic) opcodes
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int nbeat(input int dwidth, input int slice);
        return dwidth / slice;
    endfunction

    // Beat index width; a single-beat configuration still gets a 1-bit index.
    function automatic int beat_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-wide ALU used once per beat by alu_seq_ctrl.
// msb_cin is the carry into the slice MSB, used for the overflow flag on the final beat.
module alu_slice
    import alu_pkg::*;
#(
    parameter int SLICE = 32
) (
    input  logic [SLICE-1:0] op1,
    input  logic [SLICE-1:0] op2,
    input  logic             cin,
    input  logic [2:0]       opsel,
    input  logic             mode,
    output logic [SLICE-1:0] result,
    output logic             cout,
    output logic             msb_cin
);

    logic [SLICE:0]   sum;
    logic [SLICE-1:0] addend;

    always_comb begin
        addend  = '0;
        sum     = '0;
        result  = op1;
        cout    = 1'b0;
        msb_cin = 1'b0;
        if (!mode) begin
            if (opsel == OP_ADD || opsel == OP_SUB || opsel == OP_INC) begin
                // SUB and INC get their +1 through cin on the first beat.
                case (opsel)
                    OP_SUB:  addend = ~op2;
                    OP_INC:  addend = '0;
                    default: addend = op2;
                endcase
                sum     = {1'b0, op1} + {1'b0, addend} + {{SLICE{1'b0}}, cin};
                result  = sum[SLICE-1:0];
                cout    = sum[SLICE];
                msb_cin = op1[SLICE-1] ^ addend[SLICE-1] ^ sum[SLICE-1];
            end
        end else begin
            case (opsel)
                OP_AND:  result = op1 & op2;
                OP_OR:   result = op1 | op2;
                OP_XOR:  result = op1 ^ op2;
                OP_NOT:  result = ~op1;
                default: result = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-beat ALU controller: captures a request, runs DWIDTH/SLICE beats through
// alu_slice LSB first, then holds the response until rsp_ready.
// Optional completed-response counter is built only when ALU_SEQ_PERF_EN is defined.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are both 1;
// once valid is raised the producer holds it and its payload until that transfer.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int DWIDTH = 128,
    parameter int SLICE  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DWIDTH-1:0] op1,
    input  logic [DWIDTH-1:0] op2,
    input  logic [2:0]        opsel,
    input  logic              mode,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] result,
    output logic              c_flag,
    output logic              z_flag,
    output logic              o_flag,
    output logic              s_flag,
    input  logic              abort,
    output logic [31:0]       op_count,
    output logic [1:0]        state_dbg
);

    localparam int NBEAT = nbeat(DWIDTH, SLICE);
    localparam int BW    = beat_bits(NBEAT);
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEAT - 1);

    state_e            state_q, state_d;
    logic              ready_en_q;
    logic [BW-1:0]     beat_q;
    logic [DWIDTH-1:0] op1_q, op2_q, result_q;
    logic [2:0]        opsel_q;
    logic              mode_q, carry_q, z_acc_q;
    logic              c_q, z_q, o_q, s_q;

    logic              req_hs, rsp_hs, last_beat, is_arith, first_cin;
    logic [SLICE-1:0]  s_op1, s_op2, s_res;
    logic              s_cout, s_msb_cin;

    // req_ready stays low until the first clock after reset release.
    assign req_ready = (state_q == ST_IDLE) && ready_en_q;
    assign rsp_valid = (state_q == ST_DONE);
    assign req_hs    = req_valid && req_ready;
    assign rsp_hs    = rsp_valid && rsp_ready;
    assign last_beat = (beat_q == LAST_BEAT);
    assign state_dbg = state_q;

    assign first_cin = !mode && (opsel == OP_SUB || opsel == OP_INC);
    assign is_arith  = !mode_q && (opsel_q == OP_ADD || opsel_q == OP_SUB || opsel_q == OP_INC);

    assign s_op1 = op1_q[int'(beat_q) * SLICE +: SLICE];
    assign s_op2 = op2_q[int'(beat_q) * SLICE +: SLICE];

    assign result = result_q;
    assign c_flag = c_q;
    assign z_flag = z_q;
    assign o_flag = o_q;
    assign s_flag = s_q;

    alu_slice #(.SLICE(SLICE)) u_slice (
        .op1     (s_op1),
        .op2     (s_op2),
        .cin     (carry_q),
        .opsel   (opsel_q),
        .mode    (mode_q),
        .result  (s_res),
        .cout    (s_cout),
        .msb_cin (s_msb_cin)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_hs) state_d = ST_EXEC;
            ST_EXEC: begin
                if (abort)          state_d = ST_IDLE;
                else if (last_beat) state_d = ST_DONE;
            end
            ST_DONE: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q   <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            opsel_q  <= '0;
            mode_q   <= 1'b0;
            carry_q  <= 1'b0;
            z_acc_q  <= 1'b0;
            result_q <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            o_q      <= 1'b0;
            s_q      <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (req_hs) begin
                op1_q    <= op1;
                op2_q    <= op2;
                opsel_q  <= opsel;
                mode_q   <= mode;
                carry_q  <= first_cin;
                beat_q   <= '0;
                z_acc_q  <= 1'b1;
                result_q <= '0;
                c_q      <= 1'b0;
                z_q      <= 1'b0;
                o_q      <= 1'b0;
                s_q      <= 1'b0;
            end
        end else if (state_q == ST_EXEC && !abort) begin
            result_q[int'(beat_q) * SLICE +: SLICE] <= s_res;
            carry_q <= s_cout;
            z_acc_q <= z_acc_q && (s_res == '0);
            if (last_beat) begin
                beat_q <= '0;
                c_q    <= s_cout;
                z_q    <= z_acc_q && (s_res == '0);
                o_q    <= is_arith && (s_msb_cin ^ s_cout);
                s_q    <= s_res[SLICE-1];
            end else begin
                beat_q <= beat_q + 1'b1;
            end
        end
    end

`ifdef ALU_SEQ_PERF_EN
    logic [31:0] op_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            op_count_q <= '0;
        else if (rsp_hs && op_count_q != 32'hFFFF_FFFF)
            op_count_q <= op_count_q + 32'd1;
    end

    assign op_count = op_count_q;
`else
    assign op_count = '0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl (DWIDTH=128, SLICE=32): directed vector table,
// multi-cycle corner sequences and randomized operations against a whole-word model.
module tb_alu_seq_ctrl;

    localparam int W  = 128;
    localparam int S  = 32;
    localparam int NB = W / S;
`ifdef ALU_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         mode = 1'b0;
    logic         rsp_ready = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] op1 = '0;
    logic [W-1:0] op2 = '0;
    logic [2:0]   opsel = '0;

    logic         req_ready, rsp_valid, c_flag, z_flag, o_flag, s_flag;
    logic [W-1:0] result;
    logic [31:0]  op_count;
    logic [1:0]   state_dbg;

    int total = 0;
    int bad = 0;
    int hs_count = 0;
    logic [W-1:0] exp_q[$];

    typedef struct packed {
        logic [W-1:0] res;
        logic         c, z, o, s;
    } exp_t;

    typedef struct {
        logic [W-1:0] a, b;
        logic [2:0]   sel;
        logic         m;
        exp_t         e;
        int           hold;
    } vec_t;

    vec_t vecs[10];

    // clock/reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    alu_seq_ctrl #(.DWIDTH(W), .SLICE(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op1       (op1),
        .op2       (op2),
        .opsel     (opsel),
        .mode      (mode),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .result    (result),
        .c_flag    (c_flag),
        .z_flag    (z_flag),
        .o_flag    (o_flag),
        .s_flag    (s_flag),
        .abort     (abort),
        .op_count  (op_count),
        .state_dbg (state_dbg)
    );

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Whole-word reference: plain wide arithmetic, flags from sign rules.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [2:0] sel, input logic m);
        exp_t e;
        logic [W:0] wide;
        e = '0;
        e.res = a;
        if (!m) begin
            case (sel)
                3'b000: begin
                    wide = {1'b0, a} + {1'b0, b};
                    e.res = wide[W-1:0];
                    e.c = wide[W];
                    e.o = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
                end
                3'b100: begin
                    wide = {1'b0, a} + {1'b0, ~b} + 1;
                    e.res = wide[W-1:0];
                    e.c = wide[W];
                    e.o = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
                end
                3'b110: begin
                    wide = {1'b0, a} + 1;
                    e.res = wide[W-1:0];
                    e.c = wide[W];
                    e.o = !a[W-1] && e.res[W-1];
                end
                default: e.res = a;
            endcase
        end else begin
            case (sel)
                3'b000:  e.res = a & b;
                3'b001:  e.res = a | b;
                3'b010:  e.res = a ^ b;
                3'b011:  e.res = ~a;
                default: e.res = '0;
            endcase
        end
        e.z = (e.res == '0);
        e.s = e.res[W-1];
        return e;
    endfunction

    function automatic logic [W-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check_resp(input string name, input exp_t e);
        check({name, ".result"}, result, e.res);
        check({name, ".c"}, c_flag, e.c);
        check({name, ".z"}, z_flag, e.z);
        check({name, ".o"}, o_flag, e.o);
        check({name, ".s"}, s_flag, e.s);
    endtask

    // driver: one full request/response transaction; abort_done pulses abort while in DONE
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] sel, input logic m, input exp_t e,
                          input int hold, input bit abort_done);
        int n;
        exp_t got_e;
        exp_q.push_back(e.res);
        @(negedge clk);
        op1 = a; op2 = b; opsel = sel; mode = m; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL %s req_ready timeout got=0 exp=1", name);
            req_valid = 1'b0;
            void'(exp_q.pop_front());
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        op1 = rand_word(); op2 = rand_word();
        opsel = 3'($urandom_range(0, 7)); mode = 1'($urandom_range(0, 1));
        n = 1;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        got_e = e;
        got_e.res = exp_q.pop_front();
        if (!rsp_valid) begin
            total++; bad++;
            $display("FAIL %s rsp_valid timeout got=0 exp=1", name);
            return;
        end
        check({name, ".latency"}, W'(n), W'(NB + 1));
        check_resp(name, got_e);
        for (int i = 0; i < hold; i++) begin
            abort = abort_done;
            @(negedge clk);
            check({name, ".hold_valid"}, rsp_valid, 1'b1);
            check({name, ".hold_req_ready"}, req_ready, 1'b0);
            check_resp({name, ".hold"}, got_e);
        end
        abort = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        hs_count++;
        check({name, ".after_valid"}, rsp_valid, 1'b0);
        check({name, ".after_req_ready"}, req_ready, 1'b1);
        check({name, ".op_count"}, op_count, PERF ? W'(hs_count) : '0);
    endtask

    initial begin
        exp_t e;
        logic [W-1:0] a, b;
        logic [2:0]   sel;
        logic         m;
        bit           seen;

        vecs[0] = '{a: W'(32'hFFFF_FFFF), b: W'(1), sel: 3'b000, m: 1'b0,
                    e: '{res: W'(64'h1_0000_0000), c: 1'b0, z: 1'b0, o: 1'b0, s: 1'b0}, hold: 0};
        vecs[1] = '{a: W'(5), b: W'(5), sel: 3'b100, m: 1'b0,
                    e: '{res: '0, c: 1'b1, z: 1'b1, o: 1'b0, s: 1'b0}, hold: 1};
        vecs[2] = '{a: '0, b: W'(1), sel: 3'b100, m: 1'b0,
                    e: '{res: {W{1'b1}}, c: 1'b0, z: 1'b0, o: 1'b0, s: 1'b1}, hold: 0};
        vecs[3] = '{a: {1'b0, {(W-1){1'b1}}}, b: W'(1), sel: 3'b000, m: 1'b0,
                    e: '{res: {1'b1, {(W-1){1'b0}}}, c: 1'b0, z: 1'b0, o: 1'b1, s: 1'b1}, hold: 0};
        vecs[4] = '{a: {W{1'b1}}, b: W'(77), sel: 3'b110, m: 1'b0,
                    e: '{res: '0, c: 1'b1, z: 1'b1, o: 1'b0, s: 1'b0}, hold: 0};
        vecs[5] = '{a: {4{32'hA5C3_0F19}}, b: {4{32'hA5C3_0F19}}, sel: 3'b010, m: 1'b1,
                    e: '{res: '0, c: 1'b0, z: 1'b1, o: 1'b0, s: 1'b0}, hold: 10};
        vecs[6] = '{a: {W{1'b1}}, b: W'(16'h1234), sel: 3'b000, m: 1'b1,
                    e: '{res: W'(16'h1234), c: 1'b0, z: 1'b0, o: 1'b0, s: 1'b0}, hold: 0};
        vecs[7] = '{a: '0, b: W'(3), sel: 3'b011, m: 1'b1,
                    e: '{res: {W{1'b1}}, c: 1'b0, z: 1'b0, o: 1'b0, s: 1'b1}, hold: 0};
        vecs[8] = '{a: W'(8'h55), b: {W{1'b1}}, sel: 3'b001, m: 1'b0,
                    e: '{res: W'(8'h55), c: 1'b0, z: 1'b0, o: 1'b0, s: 1'b0}, hold: 0};
        vecs[9] = '{a: {W{1'b1}}, b: {W{1'b1}}, sel: 3'b111, m: 1'b1,
                    e: '{res: '0, c: 1'b0, z: 1'b1, o: 1'b0, s: 1'b0}, hold: 2};

        // reset state
        #1;
        check("reset.rsp_valid", rsp_valid, 1'b0);
        check("reset.req_ready", req_ready, 1'b0);
        check("reset.result", result, '0);
        check("reset.flags", {c_flag, z_flag, o_flag, s_flag}, '0);
        check("reset.op_count", op_count, '0);
        check("reset.state", state_dbg, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset.req_ready_release_cycle", req_ready, 1'b0);
        @(negedge clk);
        check("reset.req_ready_next_cycle", req_ready, 1'b1);

        // directed table (vector 1 also pulses abort while in DONE, which must be ignored)
        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].m,
                   vecs[i].e, vecs[i].hold, i == 1);
            check($sformatf("vec%0d.model", i), model(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].m),
                  vecs[i].e);
        end

        // abort during beat 2
        @(negedge clk);
        op1 = rand_word(); op2 = rand_word(); opsel = 3'b000; mode = 1'b0; req_valid = 1'b1;
        check("abort.req_ready", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort.req_ready_next", req_ready, 1'b1);
        check("abort.rsp_valid_next", rsp_valid, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("abort.no_response", seen, 1'b0);

        // reset pulse mid-EXEC: outputs clear without a clock edge
        @(negedge clk);
        op1 = {W{1'b1}}; op2 = {W{1'b1}}; opsel = 3'b000; mode = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset.rsp_valid", rsp_valid, 1'b0);
        check("midreset.req_ready", req_ready, 1'b0);
        check("midreset.result", result, '0);
        check("midreset.flags", {c_flag, z_flag, o_flag, s_flag}, '0);
        check("midreset.state", state_dbg, '0);
        check("midreset.op_count", op_count, '0);
        hs_count = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midreset.req_ready_release", req_ready, 1'b0);
        @(negedge clk);
        check("midreset.req_ready_after", req_ready, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("midreset.no_response", seen, 1'b0);

        // back-to-back requests
        for (int i = 0; i < 3; i++) begin
            a = rand_word(); b = rand_word();
            run_op($sformatf("b2b%0d", i), a, b, 3'b000, 1'b0, model(a, b, 3'b000, 1'b0), 0, 1'b0);
        end
        check("b2b.op_count", op_count, PERF ? W'(3) : '0);

        // randomized operations
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: a = {W{1'b1}};
                1: a = W'($urandom());
                default: a = rand_word();
            endcase
            b = ($urandom_range(0, 4) == 0) ? a : rand_word();
            sel = 3'($urandom_range(0, 7));
            m = 1'($urandom_range(0, 1));
            run_op($sformatf("rnd%0d", i), a, b, sel, m, model(a, b, sel, m),
                   $urandom_range(0, 3), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
